// File: rtl/text_console.sv
// Character-terminal engine: turns host register writes into character-buffer
// writes, tracking a hardware cursor and running line-clear and full-screen fills.
module text_console #(
    parameter int         COLS  = 160,
    parameter int         ROWS  = 64,
    parameter int         COL_W = 8,
    parameter int         ROW_W = 6,
    parameter logic [7:0] BASE  = 8'h10
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_adr,
    input  logic [15:0]            wr_data,
    output logic                   busy,
    output logic                   overrun,
    output logic [COL_W-1:0]       cur_col,
    output logic [ROW_W-1:0]       cur_row,
    output logic                   cb_we,
    output logic [COL_W+ROW_W-1:0] cb_adr,
    output logic [7:0]             cb_data
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [7:0]       ADR_CURSOR = BASE;
    localparam logic [7:0]       ADR_PUTC   = BASE + 8'd1;
    localparam logic [7:0]       ADR_CLEAR  = BASE + 8'd2;
    localparam logic [7:0]       ADR_OVRCLR = BASE + 8'd3;
    localparam logic [7:0]       CH_CR    = 8'h0D;
    localparam logic [7:0]       CH_BS    = 8'h08;
    localparam logic [7:0]       CH_LF    = 8'h0A;
    localparam logic [7:0]       CH_SPACE = 8'h20;

    // S_WRAP holds off one cycle so the wrapped character's own write is not
    // overlapped by the first line-clear write.
    typedef enum logic [1:0] {S_IDLE, S_WRAP, S_LINE, S_FILL} state_t;

    state_t                   state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         idx_q, idx_d;
    logic [ROW_W-1:0]         frow_q, frow_d;
    logic [7:0]               fdata_q, fdata_d;
    logic                     busy_q, busy_d;
    logic                     ovr_q, ovr_d;
    logic                     we_q, we_d;
    logic [COL_W+ROW_W-1:0]   adr_q, adr_d;
    logic [7:0]               data_q, data_d;

    logic                     is_cursor, is_putc, is_clear, is_ovrclr;
    logic [ROW_W-1:0]         next_row;
    logic [ROW_W-1:0]         next_frow;
    logic [31:0]              col_raw, row_raw;
    logic [7:0]               ch;
    logic                     unused_hi;

    assign is_cursor = wr_en && (wr_adr == ADR_CURSOR);
    assign is_putc   = wr_en && (wr_adr == ADR_PUTC);
    assign is_clear  = wr_en && (wr_adr == ADR_CLEAR);
    assign is_ovrclr = wr_en && (wr_adr == ADR_OVRCLR);
    assign ch        = wr_data[7:0];
    assign col_raw   = 32'(wr_data[7:0]);
    assign row_raw   = 32'(wr_data[ROW_W+7:8]);
    assign unused_hi = ^wr_data[15:ROW_W+8];
    assign next_row  = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    assign next_frow = frow_q + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            frow_q  <= '0;
            fdata_q <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            frow_q  <= frow_d;
            fdata_q <= fdata_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        idx_d   = idx_q;
        frow_d  = frow_q;
        fdata_d = fdata_q;
        ovr_d   = ovr_q;
        we_d    = 1'b0;
        adr_d   = adr_q;
        data_d  = data_q;

        if (is_ovrclr) begin
            ovr_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (is_cursor) begin
                    col_d = (col_raw >= 32'(COLS)) ? COL_LAST : COL_W'(wr_data[7:0]);
                    row_d = (row_raw >= 32'(ROWS)) ? ROW_LAST : wr_data[ROW_W+7:8];
                end else if (is_putc) begin
                    unique case (ch)
                        CH_CR: col_d = '0;
                        CH_BS: begin
                            if (col_q != '0) col_d = col_q - 1'b1;
                        end
                        CH_LF: begin
                            col_d   = '0;
                            row_d   = next_row;
                            idx_d   = '0;
                            state_d = S_LINE;
                            we_d    = 1'b1;
                            adr_d   = {next_row, COL_W'(0)};
                            data_d  = CH_SPACE;
                        end
                        default: begin
                            we_d   = 1'b1;
                            adr_d  = {row_q, col_q};
                            data_d = ch;
                            if (col_q == COL_LAST) begin
                                col_d   = '0;
                                row_d   = next_row;
                                state_d = S_WRAP;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    endcase
                end else if (is_clear) begin
                    col_d   = '0;
                    row_d   = '0;
                    idx_d   = '0;
                    frow_d  = '0;
                    fdata_d = ch;
                    state_d = S_FILL;
                    we_d    = 1'b1;
                    adr_d   = '0;
                    data_d  = ch;
                end
            end
            S_WRAP: begin
                idx_d   = '0;
                state_d = S_LINE;
                we_d    = 1'b1;
                adr_d   = {row_q, COL_W'(0)};
                data_d  = CH_SPACE;
            end
            S_LINE: begin
                if (idx_q == COL_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    we_d   = 1'b1;
                    adr_d  = {row_q, idx_q + 1'b1};
                    data_d = CH_SPACE;
                end
            end
            S_FILL: begin
                if (idx_q == COL_LAST) begin
                    if (frow_q == ROW_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d  = '0;
                        frow_d = next_frow;
                        we_d   = 1'b1;
                        adr_d  = {next_frow, COL_W'(0)};
                        data_d = fdata_q;
                    end
                end else begin
                    idx_d  = idx_q + 1'b1;
                    we_d   = 1'b1;
                    adr_d  = {frow_q, idx_q + 1'b1};
                    data_d = fdata_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && (is_cursor || is_putc || is_clear)) begin
            ovr_d = 1'b1;
        end

        busy_d = (state_d == S_LINE) || (state_d == S_FILL);
    end

    assign busy    = busy_q;
    assign overrun = ovr_q;
    assign cur_col = col_q;
    assign cur_row = row_q;
    assign cb_we   = we_q;
    assign cb_adr  = adr_q;
    assign cb_data = data_q;

endmodule
